// File: rtl/spi_slave_wb_master_if.sv
// Wishbone classic bus bundle between the SPI slave bridge (master side)
// and the on-chip memory map (slave side).
interface spi_slave_wb_master_if;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic        ack;
   logic        err;

   modport master (
      output adr, dat_w, sel, we, cyc, stb,
      input  dat_r, ack, err
   );

   modport slave (
      input  adr, dat_w, sel, we, cyc, stb,
      output dat_r, ack, err
   );
endinterface

// File: rtl/spi_slave_wb_master.sv
// SPI mode-0 slave that lets an external host issue Wishbone read/write/status
// transactions. All SPI pads are oversampled by wb_clk_i; SCLK is never a clock.
module spi_slave_wb_master #(
   parameter int          SYNC_STAGES     = 2,
   parameter logic [31:0] RD_TIMEOUT_FILL = 32'hFFFF_FFFF
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         sclk_pad_i,
   input  logic                         ss_pad_i,
   input  logic                         mosi_pad_i,
   output logic                         miso_pad_o,
   output logic                         miso_oe_o,
   output logic                         busy_o,
   spi_slave_wb_master_if.master        wb
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CMD   = 3'd1;
   localparam logic [2:0] ST_ADDR  = 3'd2;
   localparam logic [2:0] ST_WDATA = 3'd3;
   localparam logic [2:0] ST_DUMMY = 3'd4;
   localparam logic [2:0] ST_RDATA = 3'd5;
   localparam logic [2:0] ST_STAT  = 3'd6;
   localparam logic [2:0] ST_SKIP  = 3'd7;

   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_READ   = 8'h03;
   localparam logic [7:0] CMD_STATUS = 8'h05;

   // ---------------------------------------------------------------- sync
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_q;
   logic                   ss_q;

   // NOTE: the ss chain resets to the deselected level so leaving reset
   // never looks like a chip-select falling edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_q    <= 1'b0;
         ss_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pad_i};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   ss_pad_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pad_i};
         sclk_q    <= sclk_sync[SYNC_STAGES-1];
         ss_q      <= ss_sync[SYNC_STAGES-1];
      end
   end

   logic sclk_s, ss_s, mosi_s;
   logic sclk_rise, sclk_fall, ss_fall;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s &  sclk_q;
   assign ss_fall   = ~ss_s   &  ss_q;

   // ---------------------------------------------------------------- state
   logic [2:0]  state;
   logic [5:0]  bit_cnt;
   logic [7:0]  cmd_q;
   logic [31:0] shift_in;
   logic [31:0] addr_q;
   logic [31:0] out_sr;
   logic        load_pending;
   logic        err_flag;
   logic        launch_q;
   logic        rd_done;
   logic [31:0] rd_data;

   logic [7:0]  cmd_next;
   logic [31:0] shift_next;
   logic        wb_busy;
   logic        cmd_valid;

   assign cmd_next   = {cmd_q[6:0], mosi_s};
   assign shift_next = {shift_in[30:0], mosi_s};
   // A launch is already committed one cycle before cyc rises.
   assign wb_busy    = wb.cyc | launch_q;
   assign cmd_valid  = (cmd_next == CMD_WRITE) || (cmd_next == CMD_READ) ||
                       (cmd_next == CMD_STATUS);

   // NOTE: every register below is updated with non-blocking assignments so
   // all branches see the pre-edge values; later statements win on conflict.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         cmd_q        <= '0;
         shift_in     <= '0;
         addr_q       <= '0;
         out_sr       <= '0;
         load_pending <= 1'b0;
         err_flag     <= 1'b0;
         launch_q     <= 1'b0;
         rd_done      <= 1'b0;
         rd_data      <= '0;
         wb.adr       <= '0;
         wb.dat_w     <= '0;
         wb.we        <= 1'b0;
         wb.cyc       <= 1'b0;
         wb.stb       <= 1'b0;
      end else begin
         launch_q <= 1'b0;

         if (state != ST_IDLE && ss_s) begin
            // Host deselected mid-frame: drop partial shifts, keep any bus cycle.
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (ss_fall) begin
                     state   <= wb_busy ? ST_SKIP : ST_CMD;
                     bit_cnt <= '0;
                  end
               end

               ST_CMD: begin
                  if (sclk_rise) begin
                     cmd_q <= cmd_next;
                     if (bit_cnt == 6'd7) begin
                        bit_cnt <= '0;
                        state   <= cmd_valid ? ST_ADDR : ST_SKIP;
                     end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                  end
               end

               ST_ADDR: begin
                  if (sclk_rise) begin
                     shift_in <= shift_next;
                     if (bit_cnt == 6'd31) begin
                        bit_cnt <= '0;
                        addr_q  <= shift_next;
                        if (!wb_busy && cmd_q != CMD_STATUS)
                           wb.adr <= shift_next;
                        case (cmd_q)
                           CMD_READ: begin
                              rd_done <= 1'b0;
                              if (wb_busy) begin
                                 err_flag <= 1'b1;
                              end else begin
                                 wb.we    <= 1'b0;
                                 launch_q <= 1'b1;
                              end
                              state <= ST_DUMMY;
                           end
                           CMD_WRITE: state <= ST_WDATA;
                           default: begin
                              state        <= ST_STAT;
                              load_pending <= 1'b1;
                           end
                        endcase
                     end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                  end
               end

               ST_WDATA: begin
                  if (sclk_rise) begin
                     shift_in <= shift_next;
                     if (bit_cnt == 6'd31) begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                        if (wb_busy) begin
                           err_flag <= 1'b1;
                        end else begin
                           wb.adr   <= addr_q;
                           wb.dat_w <= shift_next;
                           wb.we    <= 1'b1;
                           launch_q <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                  end
               end

               ST_DUMMY: begin
                  if (sclk_rise) begin
                     if (bit_cnt == 6'd7) begin
                        bit_cnt      <= '0;
                        state        <= ST_RDATA;
                        load_pending <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                  end
               end

               ST_RDATA, ST_STAT: begin
                  if (sclk_fall) begin
                     load_pending <= 1'b0;
                     if (!load_pending) begin
                        out_sr <= {out_sr[30:0], 1'b0};
                     end else if (state == ST_STAT) begin
                        // Status busy bit reports the bus side; the frame itself is always active here.
                        out_sr <= {6'b0, err_flag, wb.cyc, 24'b0};
                     end else if (rd_done) begin
                        out_sr <= rd_data;
                     end else begin
                        out_sr   <= RD_TIMEOUT_FILL;
                        err_flag <= 1'b1;
                     end
                  end
                  if (sclk_rise) begin
                     if (state == ST_STAT && bit_cnt == 6'd7)
                        err_flag <= 1'b0;
                     if (bit_cnt != 6'd63)
                        bit_cnt <= bit_cnt + 6'd1;
                  end
               end

               default: ;  // ST_SKIP waits for ss high
            endcase
         end

         // Wishbone master: one outstanding cycle, held stable until terminated.
         if (wb.cyc) begin
            if (wb.ack || wb.err) begin
               wb.cyc <= 1'b0;
               wb.stb <= 1'b0;
               if (!wb.we) begin
                  rd_data <= wb.dat_r;
                  rd_done <= 1'b1;
               end
               if (wb.err)
                  err_flag <= 1'b1;
            end
         end else if (launch_q) begin
            wb.cyc <= 1'b1;
            wb.stb <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   logic shifting;

   assign shifting   = (state == ST_RDATA || state == ST_STAT) && !load_pending;
   assign miso_oe_o  = ~ss_s;
   assign miso_pad_o = ~ss_s & shifting & out_sr[31];
   assign busy_o     = (state != ST_IDLE) | wb.cyc;
   assign wb.sel     = 4'hF;

endmodule

// File: tb/tb_spi_slave_wb_master.sv
// Directed bench for spi_slave_wb_master: bit-banged SPI host plus a
// Wishbone slave responder with programmable ack latency.
module tb_spi_slave_wb_master;

   localparam int CLK_HALF = 5;
   localparam int SYNC     = 2;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic sclk = 1'b0;
   logic ss   = 1'b1;
   logic mosi = 1'b0;
   logic miso;
   logic miso_oe;
   logic busy;

   spi_slave_wb_master_if wb ();

   spi_slave_wb_master #(
      .SYNC_STAGES     (SYNC),
      .RD_TIMEOUT_FILL (32'hFFFF_FFFF)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .sclk_pad_i (sclk),
      .ss_pad_i   (ss),
      .mosi_pad_i (mosi),
      .miso_pad_o (miso),
      .miso_oe_o  (miso_oe),
      .busy_o     (busy),
      .wb         (wb)
   );

   always #CLK_HALF clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------- bus responder
   int          ack_delay = 3;
   logic [31:0] rsp_data  = '0;
   int          cyc_count = 0;
   int          ack_count = 0;
   int          hold_bad  = 0;
   int          late_drop = 0;
   logic [31:0] last_adr, last_dat;
   logic        last_we;
   logic [3:0]  last_sel;

   initial begin
      wb.ack   = 1'b0;
      wb.err   = 1'b0;
      wb.dat_r = '0;
      forever begin
         @(negedge clk);
         if (wb.cyc && wb.stb) begin
            cyc_count++;
            last_adr = wb.adr;
            last_dat = wb.dat_w;
            last_we  = wb.we;
            last_sel = wb.sel;
            for (int n = 0; n < ack_delay && wb.cyc; n++) begin
               @(negedge clk);
               if (wb.cyc && (wb.adr !== last_adr || wb.dat_w !== last_dat ||
                              wb.we !== last_we || wb.stb !== 1'b1))
                  hold_bad++;
            end
            if (wb.cyc) begin
               wb.dat_r = rsp_data;
               wb.ack   = 1'b1;
               @(negedge clk);
               wb.ack = 1'b0;
               ack_count++;
               if (wb.cyc) late_drop++;
            end
         end
      end
   end

   // MISO activity monitor for the skipped-command frame.
   bit mon_en  = 1'b0;
   int miso_hi = 0;
   always @(negedge clk) if (mon_en && miso) miso_hi++;

   // ---------------------------------------------------------- SPI host
   task automatic spi_start();
      @(negedge clk);
      ss = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
      rx = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = tx[i];
         repeat (4) @(negedge clk);
         rx   = {rx[30:0], miso};
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_end();
      repeat (4) @(negedge clk);
      ss   = 1'b1;
      mosi = 1'b0;
      repeat (16) @(negedge clk);
   endtask

   task automatic status_frame(output logic [31:0] st);
      logic [31:0] dummy;
      spi_start();
      spi_xfer(32'h05, 8, dummy);
      spi_xfer(32'h0, 32, dummy);
      spi_xfer(32'h0, 8, st);
      spi_end();
   endtask

   task automatic read_frame(input logic [31:0] adr, output logic [31:0] rd);
      logic [31:0] dummy;
      spi_start();
      spi_xfer(32'h03, 8, dummy);
      spi_xfer(adr, 32, dummy);
      spi_xfer(32'h0, 8, dummy);
      spi_xfer(32'h0, 32, rd);
   endtask

   task automatic write_frame(input logic [31:0] adr, input logic [31:0] dat, output logic [31:0] rx);
      logic [31:0] dummy;
      spi_start();
      spi_xfer(32'h02, 8, dummy);
      spi_xfer(adr, 32, dummy);
      spi_xfer(dat, 32, rx);
      spi_end();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------- sequence
   initial begin
      logic [31:0] rx, rx2;
      int          base;

      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ctrl", {26'b0, wb.cyc, wb.stb, wb.we, miso, miso_oe, busy}, 32'h0);
      check("reset_adr", wb.adr, 32'h0);
      check("reset_dat", wb.dat_w, 32'h0);
      check("sel_const", {28'b0, wb.sel}, 32'hF);

      // Write 0xCAFEBABE to 0x10, ack after 3 clocks.
      ack_delay = 3;
      write_frame(32'h0000_0010, 32'hCAFE_BABE, rx);
      check("wr_cycles", cyc_count, 1);
      check("wr_acks", ack_count, 1);
      check("wr_adr", last_adr, 32'h0000_0010);
      check("wr_dat", last_dat, 32'hCAFE_BABE);
      check("wr_we", {31'b0, last_we}, 32'h1);
      check("wr_sel", {28'b0, last_sel}, 32'hF);
      check("wr_hold", hold_bad, 0);
      check("wr_drop", late_drop, 0);
      check("wr_miso", rx, 32'h0);
      check("wr_idle", {30'b0, wb.cyc, busy}, 32'h0);

      // Read 0x10, data 0x12345678 ready after 2 clocks.
      ack_delay = 2;
      rsp_data  = 32'h1234_5678;
      read_frame(32'h0000_0010, rx);
      spi_end();
      check("rd_data", rx, 32'h1234_5678);
      check("rd_cycles", cyc_count, 2);
      check("rd_adr", last_adr, 32'h0000_0010);
      check("rd_we", {31'b0, last_we}, 32'h0);
      check("rd_hold", hold_bad, 0);

      // Read whose ack arrives too late for the dummy window.
      ack_delay = 200;
      rsp_data  = 32'hDEAD_BEEF;
      read_frame(32'h0000_0040, rx);
      spi_end();
      check("to_fill", rx, 32'hFFFF_FFFF);
      check("to_acks", ack_count, 3);
      status_frame(rx);
      check("stat_err", rx, 32'h02);
      status_frame(rx);
      check("stat_clr", rx, 32'h00);

      // Abort a read after 20 address bits.
      base = cyc_count;
      spi_start();
      spi_xfer(32'h03, 8, rx);
      spi_xfer(32'h0001_2345, 20, rx);
      ss = 1'b1;
      repeat (SYNC + 2) @(negedge clk);
      check("abort_busy", {31'b0, busy}, 32'h0);
      repeat (40) @(negedge clk);
      check("abort_nocyc", cyc_count, base);

      // Unknown command 0xA5 is skipped, then a normal write follows.
      ack_delay = 3;
      base      = cyc_count;
      spi_start();
      mon_en = 1'b1;
      spi_xfer(32'hA5, 8, rx);
      spi_xfer(32'hFFFF_FFFF, 32, rx);
      spi_xfer(32'h5555_AAAA, 32, rx2);
      mon_en = 1'b0;
      spi_end();
      check("skip_miso_a", rx, 32'h0);
      check("skip_miso_b", rx2, 32'h0);
      check("skip_mon", miso_hi, 0);
      check("skip_nocyc", cyc_count, base);
      write_frame(32'h0000_0020, 32'h0BAD_F00D, rx);
      check("post_cycles", cyc_count, base + 1);
      check("post_adr", last_adr, 32'h0000_0020);
      check("post_dat", last_dat, 32'h0BAD_F00D);

      // Reset while a read cycle is outstanding (ack never comes in time).
      ack_delay = 1000;
      read_frame(32'h0000_0030, rx);
      check("rst_fill", rx, 32'hFFFF_FFFF);
      check("rst_pending", {31'b0, wb.cyc}, 32'h1);
      rst = 1'b1;
      ss  = 1'b1;
      @(negedge clk);
      check("rst_ctrl", {26'b0, wb.cyc, wb.stb, wb.we, miso, miso_oe, busy}, 32'h0);
      check("rst_adr", wb.adr, 32'h0);
      check("rst_dat", wb.dat_w, 32'h0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      ack_delay = 3;
      status_frame(rx);
      check("rst_status", rx, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
